miner_job_ctrl: RTL and testbench

MINER_JOB_CTRL -- requirements
Module: miner_job_ctrl

---
 rtl/miner_pkg.sv | 23 ++
 rtl/nbits_to_target.sv | 31 +++
 rtl/miner_job_ctrl.sv | 144 ++++++++++++++
 tb/tb_miner_job_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/miner_pkg.sv
// Shared definitions for the miner job controller.
//   state_t          : controller FSM states
//   JOB_BYTES        : inbound job frame length (80 header + 4 max_nonce)
//   HEADER_BYTES     : header portion of the job frame
//   RESULT_BYTES     : outbound result frame length (status + nonce + hash)
//   STATUS_*         : result frame status codes
package miner_pkg;

  typedef enum logic [1:0] {
    RX,
    LAUNCH,
    WAIT,
    TX
  } state_t;

  localparam int unsigned JOB_BYTES    = 84;
  localparam int unsigned HEADER_BYTES = 80;
  localparam int unsigned RESULT_BYTES = 37;

  localparam logic [7:0] STATUS_FOUND     = 8'h01;
  localparam logic [7:0] STATUS_EXHAUSTED = 8'h02;

endpackage

// File: rtl/nbits_to_target.sv
// Compact difficulty (nBits) to 256-bit target expansion, purely combinational.
//   nbits  : {exponent[7:0], sign, mantissa[22:0]}
//   target : expanded target; zero for negative or zero mantissa,
//            saturates to all-ones when the exponent exceeds 32 bytes.
module nbits_to_target (
  input  logic [31:0]  nbits,
  output logic [255:0] target
);

  logic [7:0]   exp_b;
  logic [22:0]  mant;
  logic [255:0] mant_ext;

  assign exp_b    = nbits[31:24];
  assign mant     = nbits[22:0];
  assign mant_ext = {233'd0, mant};

  always_comb begin
    target = '0;
    if (nbits[23] || (mant == '0)) begin
      target = '0;
    end else if (exp_b > 8'd32) begin
      target = '1;
    end else if (exp_b <= 8'd3) begin
      target = mant_ext >> (32'd8 * (32'd3 - 32'(exp_b)));
    end else begin
      target = mant_ext << (32'd8 * (32'(exp_b) - 32'd3));
    end
  end

endmodule

// File: rtl/miner_job_ctrl.sv
// Miner job controller: receives an 84-byte job frame, expands the compact
// target, launches the miner, waits for found/exhausted and streams back a
// 37-byte result frame.
//   clk, rst                       : clock, async active-high reset
//   rx_data/rx_valid/rx_ready      : inbound job byte stream
//   tx_data/tx_valid/tx_ready      : outbound result byte stream
//   miner_start/header/target/max_nonce : job handed to the miner core
//   miner_busy/found/exhausted/nonce/hash : miner status (busy is debug only)
//   ctrl_busy                      : high whenever not accepting a job
//   jobs_done                      : completed job count (wraps)
module miner_job_ctrl
  import miner_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   rx_data,
  input  logic         rx_valid,
  output logic         rx_ready,
  output logic [7:0]   tx_data,
  output logic         tx_valid,
  input  logic         tx_ready,
  output logic         miner_start,
  output logic [639:0] miner_header,
  output logic [255:0] miner_target,
  output logic [31:0]  miner_max_nonce,
  input  logic         miner_busy,
  input  logic         miner_found,
  input  logic         miner_exhausted,
  input  logic [31:0]  miner_nonce,
  input  logic [255:0] miner_hash,
  output logic         ctrl_busy,
  output logic [15:0]  jobs_done
);

  state_t         state, state_nxt;
  logic [6:0]     rx_cnt;
  logic [5:0]     tx_cnt;
  logic [295:0]   result_sr;
  logic [255:0]   target_w;
  logic [31:0]    nbits;
  logic           rx_last, tx_last, miner_done;
  logic           debug_unused;

  // miner_busy is observed for debug only and never steers control.
  assign debug_unused = miner_busy;

  // nBits is header bytes 72..75, little-endian.
  assign nbits = {miner_header[39:32], miner_header[47:40],
                  miner_header[55:48], miner_header[63:56]};

  nbits_to_target u_target (
    .nbits  (nbits),
    .target (target_w)
  );

  assign rx_last    = (rx_cnt == 7'(JOB_BYTES - 1));
  assign tx_last    = (tx_cnt == 6'(RESULT_BYTES - 1));
  assign miner_done = miner_found | miner_exhausted;

  // The result is held pre-serialised in a shift register: the head byte
  // is always the next byte to send, and it drains to zero after the frame.
  assign tx_data = result_sr[295:288];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RX;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rx_ready  = 1'b0;
    tx_valid  = 1'b0;
    ctrl_busy = 1'b1;
    case (state)
      RX: begin
        rx_ready  = 1'b1;
        ctrl_busy = 1'b0;
        if (rx_valid && rx_last) state_nxt = LAUNCH;
      end
      LAUNCH: state_nxt = WAIT;
      WAIT: if (miner_done) state_nxt = TX;
      TX: begin
        tx_valid = 1'b1;
        if (tx_ready && tx_last) state_nxt = RX;
      end
      default: state_nxt = RX;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_cnt          <= '0;
      tx_cnt          <= '0;
      result_sr       <= '0;
      miner_start     <= 1'b0;
      miner_header    <= '0;
      miner_target    <= '0;
      miner_max_nonce <= '0;
      jobs_done       <= '0;
    end else begin
      case (state)
        RX: begin
          if (rx_valid) begin
            for (int unsigned i = 0; i < HEADER_BYTES; i++) begin
              if (rx_cnt == 7'(i)) miner_header[639 - 8*i -: 8] <= rx_data;
            end
            for (int unsigned i = 0; i < 4; i++) begin
              if (rx_cnt == 7'(HEADER_BYTES + i)) miner_max_nonce[8*i +: 8] <= rx_data;
            end
            rx_cnt <= rx_last ? '0 : rx_cnt + 7'd1;
          end
        end
        LAUNCH: begin
          miner_target <= target_w;
          miner_start  <= 1'b1;
          tx_cnt       <= '0;
        end
        WAIT: begin
          if (miner_done) begin
            miner_start <= 1'b0;
            // Found wins over exhausted; nonce goes out LSB first, hash MSB first.
            result_sr <= {(miner_found ? STATUS_FOUND : STATUS_EXHAUSTED),
                          miner_nonce[7:0], miner_nonce[15:8],
                          miner_nonce[23:16], miner_nonce[31:24],
                          miner_hash};
          end
        end
        TX: begin
          if (tx_ready) begin
            result_sr <= {result_sr[287:0], 8'h00};
            tx_cnt    <= tx_cnt + 6'd1;
            if (tx_last) begin
              tx_cnt    <= '0;
              rx_cnt    <= '0;
              jobs_done <= jobs_done + 16'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_miner_job_ctrl.sv
module tb_miner_job_ctrl;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [7:0]   rx_data = '0;
  logic         rx_valid = 1'b0;
  logic         rx_ready;
  logic [7:0]   tx_data;
  logic         tx_valid;
  logic         tx_ready = 1'b0;
  logic         miner_start;
  logic [639:0] miner_header;
  logic [255:0] miner_target;
  logic [31:0]  miner_max_nonce;
  logic         miner_busy = 1'b0;
  logic         miner_found = 1'b0;
  logic         miner_exhausted = 1'b0;
  logic [31:0]  miner_nonce = '0;
  logic [255:0] miner_hash = '0;
  logic         ctrl_busy;
  logic [15:0]  jobs_done;

  miner_job_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .rx_data         (rx_data),
    .rx_valid        (rx_valid),
    .rx_ready        (rx_ready),
    .tx_data         (tx_data),
    .tx_valid        (tx_valid),
    .tx_ready        (tx_ready),
    .miner_start     (miner_start),
    .miner_header    (miner_header),
    .miner_target    (miner_target),
    .miner_max_nonce (miner_max_nonce),
    .miner_busy      (miner_busy),
    .miner_found     (miner_found),
    .miner_exhausted (miner_exhausted),
    .miner_nonce     (miner_nonce),
    .miner_hash      (miner_hash),
    .ctrl_busy       (ctrl_busy),
    .jobs_done       (jobs_done)
  );

  always #5 clk = ~clk;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned jobs_exp = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  hdr [0:79];
  logic [31:0] frame_maxn;

  task automatic build_frame(input logic [31:0] nbits, input logic [31:0] maxn);
    for (int k = 0; k < 80; k++) hdr[k] = 8'($urandom);
    hdr[72] = nbits[7:0];
    hdr[73] = nbits[15:8];
    hdr[74] = nbits[23:16];
    hdr[75] = nbits[31:24];
    frame_maxn = maxn;
  endtask

  task automatic send_frame(input int unsigned nbytes, input bit gaps);
    for (int unsigned k = 0; k < nbytes; k++) begin
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
      if (k < 80) rx_data = hdr[k];
      else        rx_data = frame_maxn[8*(k-80) +: 8];
      rx_valid = 1'b1;
      #1;
      n_tests++;
      if (rx_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL rx_ready byte %0d: got %b want 1", k, rx_ready);
      end
      @(negedge clk);
      rx_valid = 1'b0;
    end
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    rx_valid = 1'b0;
    tx_ready = 1'b0;
    miner_found = 1'b0;
    miner_exhausted = 1'b0;
    #1;
  endtask

  task automatic run_job(input string name, input logic [31:0] nbits, input logic [255:0] tgt,
                         input logic [31:0] maxn, input bit fnd, input bit exh,
                         input logic [31:0] nonce, input logic [255:0] hash, input bit stall);
    logic [639:0] hx;
    int unsigned  guard;
    build_frame(nbits, maxn);
    for (int k = 0; k < 80; k++) hx[639 - 8*k -: 8] = hdr[k];
    send_frame(84, stall);
    // LAUNCH cycle: busy, not accepting, miner not yet started
    n_tests++;
    if ({ctrl_busy, rx_ready, miner_start} !== 3'b100) begin
      n_fail++;
      $display("FAIL %s launch {busy,rx_ready,start}: got %b want 100", name, {ctrl_busy, rx_ready, miner_start});
    end
    @(negedge clk);
    n_tests++;
    if (miner_start !== 1'b1) begin
      n_fail++;
      $display("FAIL %s start: got %b want 1", name, miner_start);
    end
    n_tests++;
    if (miner_target !== tgt) begin
      n_fail++;
      $display("FAIL %s target: got %h want %h", name, miner_target, tgt);
    end
    n_tests++;
    if (miner_header !== hx) begin
      n_fail++;
      $display("FAIL %s header: got %h want %h", name, miner_header, hx);
    end
    n_tests++;
    if (miner_max_nonce !== maxn) begin
      n_fail++;
      $display("FAIL %s max_nonce: got %h want %h", name, miner_max_nonce, maxn);
    end
    miner_busy = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({miner_start, tx_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL %s wait {start,tx_valid}: got %b want 10", name, {miner_start, tx_valid});
    end
    miner_found = fnd;
    miner_exhausted = exh;
    miner_nonce = nonce;
    miner_hash = hash;
    exp_q.push_back(fnd ? 8'h01 : 8'h02);
    for (int i = 0; i < 4; i++) exp_q.push_back(nonce[8*i +: 8]);
    for (int i = 0; i < 32; i++) exp_q.push_back(hash[255 - 8*i -: 8]);
    @(negedge clk);
    miner_found = 1'b0;
    miner_exhausted = 1'b0;
    miner_busy = 1'b0;
    miner_nonce = $urandom;
    miner_hash = ~hash;
    n_tests++;
    if ({miner_start, tx_valid} !== 2'b01) begin
      n_fail++;
      $display("FAIL %s capture {start,tx_valid}: got %b want 01", name, {miner_start, tx_valid});
    end
    guard = 0;
    while (exp_q.size() > 0 && guard < 400) begin
      tx_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (tx_valid) begin
        n_tests++;
        if (tx_data !== exp_q[0]) begin
          n_fail++;
          $display("FAIL %s tx byte %0d: got %h want %h", name, 37 - exp_q.size(), tx_data, exp_q[0]);
        end
        if (tx_ready) void'(exp_q.pop_front());
      end
      @(negedge clk);
      guard++;
    end
    tx_ready = 1'b0;
    n_tests++;
    if (guard >= 400) begin
      n_fail++;
      $display("FAIL %s tx timeout: got %0d bytes left want 0", name, exp_q.size());
      exp_q.delete();
    end
    jobs_exp++;
    n_tests++;
    if (jobs_done !== 16'(jobs_exp)) begin
      n_fail++;
      $display("FAIL %s jobs_done: got %0d want %0d", name, jobs_done, jobs_exp);
    end
    n_tests++;
    if ({tx_valid, rx_ready, ctrl_busy, miner_start} !== 4'b0100) begin
      n_fail++;
      $display("FAIL %s idle {tx_valid,rx_ready,busy,start}: got %b want 0100", name,
               {tx_valid, rx_ready, ctrl_busy, miner_start});
    end
  endtask

  task automatic test_reset();
    pulse_rst();
    n_tests++;
    if ({rx_ready, tx_valid, tx_data, miner_start, ctrl_busy, jobs_done} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 16'h0000}) begin
      n_fail++;
      $display("FAIL reset ctrl: got %b/%b/%h/%b/%b/%h want 1/0/00/0/0/0000",
               rx_ready, tx_valid, tx_data, miner_start, ctrl_busy, jobs_done);
    end
    n_tests++;
    if ({miner_header, miner_target, miner_max_nonce} !== '0) begin
      n_fail++;
      $display("FAIL reset job regs: got hdr %h tgt %h max %h want all 0", miner_header, miner_target, miner_max_nonce);
    end
    @(negedge clk);
    rst = 1'b0;
    jobs_exp = 0;
    @(negedge clk);
  endtask

  task automatic test_found();
    run_job("found", 32'h1d00ffff, 256'hFFFF << 208, 32'hDEADBEEF, 1'b1, 1'b0,
            32'h12345678, {32{8'hAB}}, 1'b0);
  endtask

  task automatic test_exhausted();
    logic [255:0] h;
    for (int i = 0; i < 8; i++) h[32*i +: 32] = $urandom;
    run_job("exhausted", 32'h02123456, 256'h1234, 32'h00001000, 1'b0, 1'b1,
            32'h000000FF, h, 1'b0);
  endtask

  task automatic test_priority();
    logic [255:0] h;
    for (int i = 0; i < 8; i++) h[32*i +: 32] = $urandom;
    run_job("priority", 32'h03123456, 256'h123456, 32'hFFFFFFFF, 1'b1, 1'b1,
            32'hCAFEF00D, h, 1'b0);
  endtask

  task automatic test_stalls();
    logic [31:0]  nb  [4] = '{32'h04923456, 32'h21000001, 32'h207FFFFF, 32'h1D000000};
    logic [255:0] tg  [4] = '{256'h0, {256{1'b1}}, 256'h7FFFFF << 232, 256'h0};
    logic [255:0] h;
    for (int j = 0; j < 4; j++) begin
      for (int i = 0; i < 8; i++) h[32*i +: 32] = $urandom;
      run_job("stall", nb[j], tg[j], $urandom, (j % 2) == 0, (j % 2) == 1, $urandom, h, 1'b1);
    end
  endtask

  task automatic test_reset_mid();
    logic seen_tx;
    // reset while the miner is running
    build_frame(32'h1d00ffff, 32'h11223344);
    send_frame(84, 1'b0);
    repeat (3) @(negedge clk);
    n_tests++;
    if (miner_start !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_wait pre start: got %b want 1", miner_start);
    end
    pulse_rst();
    n_tests++;
    if ({rx_ready, tx_valid, tx_data, miner_start, ctrl_busy, jobs_done} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 16'h0000}) begin
      n_fail++;
      $display("FAIL rst_wait ctrl: got %b/%b/%h/%b/%b/%h want 1/0/00/0/0/0000",
               rx_ready, tx_valid, tx_data, miner_start, ctrl_busy, jobs_done);
    end
    n_tests++;
    if ({miner_header, miner_target, miner_max_nonce} !== '0) begin
      n_fail++;
      $display("FAIL rst_wait job regs: got hdr %h tgt %h max %h want all 0", miner_header, miner_target, miner_max_nonce);
    end
    @(negedge clk);
    rst = 1'b0;
    jobs_exp = 0;
    miner_found = 1'b1;
    seen_tx = 1'b0;
    repeat (5) begin
      @(negedge clk);
      seen_tx |= tx_valid;
    end
    miner_found = 1'b0;
    n_tests++;
    if (seen_tx !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_wait no tx after reset: got %b want 0", seen_tx);
    end
    // reset after a partial 40-byte frame
    build_frame(32'h1d00ffff, 32'h55667788);
    send_frame(40, 1'b1);
    pulse_rst();
    n_tests++;
    if ({rx_ready, tx_valid, miner_start, ctrl_busy, miner_header} !== {1'b1, 1'b0, 1'b0, 1'b0, 640'h0}) begin
      n_fail++;
      $display("FAIL rst_rx: got rdy %b txv %b start %b busy %b hdr %h want 1 0 0 0 0",
               rx_ready, tx_valid, miner_start, ctrl_busy, miner_header);
    end
    @(negedge clk);
    rst = 1'b0;
    jobs_exp = 0;
    @(negedge clk);
    run_job("after_rst", 32'h02123456, 256'h1234, 32'h0BADF00D, 1'b1, 1'b0,
            32'h12345678, {32{8'hAB}}, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_found();
    test_exhausted();
    test_priority();
    test_stalls();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
